// File: rtl/alu_mul_sequencer_pkg.sv
// Shared ALU opcode constants and shift-add multiply sequencer state encoding.
// The datapath ALU control imports the same opcodes from here.
package alu_mul_sequencer_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned 64x64->64 (low half) multiplier that borrows the shared
// datapath ALU for its shift-add iterations.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Product,
  output logic             ProdZero,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [3:0]       AluCtrl,
  input  logic [WIDTH-1:0] AluResult
);

  seq_state_e       state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] product_q;
  logic             prod_zero_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [3:0]       alu_ctrl_q;

  logic [WIDTH-1:0] mcand_nxt_c;
  logic [WIDTH-1:0] mplier_nxt_c;
  logic             last_c;

  // Values the RUN iteration hands to the next cycle; last_c ends the loop.
  always_comb begin
    mcand_nxt_c  = mcand_q << 1;
    mplier_nxt_c = mplier_q >> 1;
    last_c       = (mplier_nxt_c == '0) || (cnt_q == CNT_W'(WIDTH - 1));
  end

  // acc_q is zero outside RUN, so it doubles as the registered BusA drive.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      prod_zero_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= ALU_AND;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            state_q    <= ST_RUN;
            acc_q      <= '0;
            mcand_q    <= OpA;
            mplier_q   <= OpB;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            alu_b_q    <= OpB[0] ? OpA : '0;
            alu_ctrl_q <= ALU_ADD;
          end
        end
        ST_RUN: begin
          mcand_q  <= mcand_nxt_c;
          mplier_q <= mplier_nxt_c;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_c) begin
            // Final sum is captured here so Product is already valid while Done is high.
            state_q     <= ST_DONE;
            acc_q       <= '0;
            product_q   <= AluResult;
            prod_zero_q <= (AluResult == '0);
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            alu_b_q     <= '0;
            alu_ctrl_q  <= ALU_AND;
          end else begin
            acc_q   <= AluResult;
            alu_b_q <= mplier_q[1] ? mcand_nxt_c : '0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          acc_q      <= '0;
          alu_b_q    <= '0;
          alu_ctrl_q <= ALU_AND;
        end
      endcase
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Product  = product_q;
  assign ProdZero = prod_zero_q;
  assign AluA     = acc_q;
  assign AluB     = alu_b_q;
  assign AluCtrl  = alu_ctrl_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: behavioural ALU beside the DUT, table of
// operations plus hand sequences for Start-while-busy and mid-run reset.
module tb_alu_mul_sequencer;
  import alu_mul_sequencer_pkg::*;

  localparam int unsigned W = 64;

  logic          CLK;
  logic          Reset;
  logic          Start;
  logic [W-1:0]  OpA;
  logic [W-1:0]  OpB;
  logic          Busy;
  logic          Done;
  logic [W-1:0]  Product;
  logic          ProdZero;
  logic [W-1:0]  AluA;
  logic [W-1:0]  AluB;
  logic [3:0]    AluCtrl;
  logic [W-1:0]  AluResult;

  alu_mul_sequencer #(.WIDTH(W), .CNT_W(7)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .OpA(OpA), .OpB(OpB),
    .Busy(Busy), .Done(Done), .Product(Product), .ProdZero(ProdZero),
    .AluA(AluA), .AluB(AluB), .AluCtrl(AluCtrl), .AluResult(AluResult)
  );

  // Stand-in for the datapath ALU
  always_comb begin
    case (AluCtrl)
      ALU_AND:   AluResult = AluA & AluB;
      ALU_OR:    AluResult = AluA | AluB;
      ALU_ADD:   AluResult = AluA + AluB;
      ALU_SUB:   AluResult = AluA - AluB;
      ALU_PASSB: AluResult = AluB;
      default:   AluResult = '0;
    endcase
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] prod;
    int           runs;
  } vec_t;

  typedef struct {
    logic [W-1:0] prod;
    int           runs;
  } exp_t;

  typedef struct {
    logic [W-1:0] prod;
    logic         zero;
    int           runs;
    logic         ctrl_bad;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   run_cnt = 0;
  logic ctrl_bad = 1'b0;
  logic idle_bad = 1'b0;
  logic both_bad = 1'b0;

  // Observer: counts Busy cycles per operation and records each Done pulse.
  always @(negedge CLK) begin
    if (Reset) begin
      run_cnt  = 0;
      ctrl_bad = 1'b0;
    end else begin
      if (Busy) begin
        run_cnt = run_cnt + 1;
        if (AluCtrl != ALU_ADD) ctrl_bad = 1'b1;
      end else if (AluCtrl != ALU_AND || AluA != '0 || AluB != '0) begin
        idle_bad = 1'b1;
      end
      if (Busy && Done) both_bad = 1'b1;
      if (Done) begin
        obs_q.push_back('{prod: Product, zero: ProdZero, runs: run_cnt, ctrl_bad: ctrl_bad});
        run_cnt  = 0;
        ctrl_bad = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int runs_for(input logic [W-1:0] b);
    int k = 0;
    for (int i = 0; i < int'(W); i++) if (b[i]) k = i;
    return k + 1;
  endfunction

  // Drive one Start pulse, then scramble the operands to show they are not re-sampled.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    Start = 1'b1;
    OpA   = a;
    OpB   = b;
    @(negedge CLK);
    Start = 1'b0;
    OpA   = ~a;
    OpB   = ~b;
  endtask

  task automatic wait_and_compare(input string name);
    exp_t e;
    obs_t o;
    int   waited = 0;
    while (obs_q.size() == 0 && waited < 120) begin
      @(negedge CLK);
      waited++;
    end
    n_cmp++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s_done: got no Done within %0d cycles, expected one", name, waited);
      exp_q.delete();
      return;
    end
    e = exp_q.pop_front();
    o = obs_q.pop_front();
    check({name, "_product"}, o.prod, e.prod);
    check({name, "_zero"}, W'(o.zero), W'(e.prod == '0));
    check({name, "_runs"}, W'(o.runs), W'(e.runs));
    check({name, "_ctrl"}, W'(o.ctrl_bad), W'(0));
  endtask

  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] prod, input int runs);
    exp_q.push_back('{prod: prod, runs: runs});
    start_op(a, b);
    wait_and_compare(name);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{a: 64'd3,                    b: 64'd5,                    prod: 64'hF,                 runs: 3};
    vecs[1] = '{a: 64'h1234,                 b: 64'd0,                    prod: 64'd0,                 runs: 1};
    vecs[2] = '{a: 64'd0,                    b: 64'hFF,                   prod: 64'd0,                 runs: 8};
    vecs[3] = '{a: 64'd1,                    b: 64'hFFFF_FFFF_FFFF_FFFF,  prod: 64'hFFFF_FFFF_FFFF_FFFF, runs: 64};
    vecs[4] = '{a: 64'h8000_0000_0000_0000,  b: 64'd2,                    prod: 64'd0,                 runs: 2};
    vecs[5] = '{a: 64'h1_0000_0001,          b: 64'h1_0000_0000,          prod: 64'h1_0000_0000,       runs: 33};
    vecs[6] = '{a: 64'hFFFF_FFFF_FFFF_FFFF,  b: 64'd1,                    prod: 64'hFFFF_FFFF_FFFF_FFFF, runs: 1};
    vecs[7] = '{a: 64'hFFFF_FFFF_FFFF_FFFF,  b: 64'd3,                    prod: 64'hFFFF_FFFF_FFFF_FFFD, runs: 2};

    Reset = 1'b1;
    Start = 1'b0;
    OpA   = '0;
    OpB   = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy", W'(Busy), W'(0));
    check("rst_done", W'(Done), W'(0));
    check("rst_product", Product, '0);
    check("rst_zero", W'(ProdZero), W'(1));
    check("rst_ctrl", W'(AluCtrl), W'(ALU_AND));
    Reset = 1'b0;

    for (int i = 0; i < 8; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].runs);

    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()} >> $urandom_range(0, 60);
      do_op($sformatf("rnd%0d", i), a, b, a * b, runs_for(b));
    end

    // A Start during RUN must be dropped, not queued.
    exp_q.push_back('{prod: 64'h100, runs: 5});
    start_op(64'h10, 64'h10);
    Start = 1'b1;
    OpA   = 64'd7;
    OpB   = 64'd7;
    @(negedge CLK);
    Start = 1'b0;
    wait_and_compare("busy_start");
    repeat (12) @(negedge CLK);
    check("busy_start_extra_done", W'(obs_q.size()), W'(0));

    // Reset in the 10th RUN cycle of a 64-cycle operation.
    exp_q.push_back('{prod: 64'hFFFF_FFFF_FFFF_FFFF, runs: 64});
    start_op(64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (9) @(negedge CLK);
    check("mid_busy_before", W'(Busy), W'(1));
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    check("mid_rst_busy", W'(Busy), W'(0));
    check("mid_rst_done", W'(Done), W'(0));
    check("mid_rst_product", Product, '0);
    check("mid_rst_zero", W'(ProdZero), W'(1));
    exp_q.delete();
    repeat (70) @(negedge CLK);
    check("mid_rst_no_done", W'(obs_q.size()), W'(0));
    do_op("after_rst", 64'd6, 64'd7, 64'h2A, 3);

    check("idle_alu_drive", W'(idle_bad), W'(0));
    check("busy_done_overlap", W'(both_bad), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
